// File: rtl/rv32_pkg.sv
// Shared definitions for the RV32I multi-cycle control path: opcodes,
// sequencer states, instruction classes and datapath select encodings.
package rv32_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_TRAP
    } state_t;

    typedef enum logic [3:0] {
        CL_OP,
        CL_OPIMM,
        CL_LUI,
        CL_AUIPC,
        CL_JAL,
        CL_JALR,
        CL_BRANCH,
        CL_LOAD,
        CL_STORE,
        CL_FENCE,
        CL_ILLEGAL
    } op_class_t;

    localparam logic [1:0] PC_SEL_PLUS4 = 2'd0;
    localparam logic [1:0] PC_SEL_IMM   = 2'd1;
    localparam logic [1:0] PC_SEL_JALR  = 2'd2;

    localparam logic [1:0] WB_SEL_ALU   = 2'd0;
    localparam logic [1:0] WB_SEL_MEM   = 2'd1;
    localparam logic [1:0] WB_SEL_PC4   = 2'd2;
    localparam logic [1:0] WB_SEL_IMM   = 2'd3;

    localparam logic ALU_A_RS1 = 1'b0;
    localparam logic ALU_A_PC  = 1'b1;
    localparam logic ALU_B_RS2 = 1'b0;
    localparam logic ALU_B_IMM = 1'b1;

endpackage

// File: rtl/opcode_class.sv
// Combinational opcode to instruction-class mapper; anything not in the
// supported RV32I base set (SYSTEM included) is flagged illegal.
module opcode_class
    import rv32_pkg::*;
(
    input  logic [6:0] opcode,
    output op_class_t  cls,
    output logic       illegal
);

    always_comb begin
        cls     = CL_ILLEGAL;
        illegal = 1'b0;
        case (opcode)
            OPC_LUI:    cls = CL_LUI;
            OPC_AUIPC:  cls = CL_AUIPC;
            OPC_JAL:    cls = CL_JAL;
            OPC_JALR:   cls = CL_JALR;
            OPC_BRANCH: cls = CL_BRANCH;
            OPC_LOAD:   cls = CL_LOAD;
            OPC_STORE:  cls = CL_STORE;
            OPC_OPIMM:  cls = CL_OPIMM;
            OPC_OP:     cls = CL_OP;
            OPC_FENCE:  cls = CL_FENCE;
            default: begin
                cls     = CL_ILLEGAL;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer driving datapath enables
// and selects, with a retired-instruction counter and sticky illegal flag.
module mc_control
    import rv32_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic [4:0]       rd,
    input  logic             branch_taken,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             alu_a_sel,
    output logic             alu_b_sel,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [2:0]       dmem_size,
    output logic             rf_we,
    output logic [1:0]       wb_sel,
    output logic             illegal,
    output logic [CNT_W-1:0] instret
);

    state_t          state_reg;
    op_class_t       cls_reg;
    logic [2:0]      funct3_reg;
    logic [4:0]      rd_reg;
    logic            illegal_reg;
    logic [CNT_W-1:0] instret_reg;

    op_class_t       dec_cls;
    logic            dec_illegal;

    opcode_class u_opcode_class (
        .opcode  (opcode),
        .cls     (dec_cls),
        .illegal (dec_illegal)
    );

    // Enables depend on the handshake inputs in the same cycle, so the
    // output decode is combinational off the state and latched class.
    always_comb begin
        imem_req  = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_sel    = PC_SEL_PLUS4;
        alu_a_sel = ALU_A_RS1;
        alu_b_sel = ALU_B_RS2;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        rf_we     = 1'b0;
        wb_sel    = WB_SEL_ALU;
        case (state_reg)
            ST_FETCH: begin
                imem_req = 1'b1;
                ir_we    = imem_ready;
            end
            ST_EXEC: begin
                if (cls_reg == CL_AUIPC)
                    alu_a_sel = ALU_A_PC;
                if (cls_reg inside {CL_AUIPC, CL_OPIMM, CL_LOAD, CL_STORE, CL_JALR})
                    alu_b_sel = ALU_B_IMM;
                if (cls_reg == CL_BRANCH) begin
                    pc_we  = 1'b1;
                    pc_sel = branch_taken ? PC_SEL_IMM : PC_SEL_PLUS4;
                end
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (cls_reg == CL_STORE);
                if (cls_reg == CL_STORE && dmem_ready)
                    pc_we = 1'b1;
            end
            ST_WB: begin
                pc_we = 1'b1;
                rf_we = (rd_reg != 5'd0) && (cls_reg != CL_FENCE);
                case (cls_reg)
                    CL_LUI:          wb_sel = WB_SEL_IMM;
                    CL_JAL, CL_JALR: wb_sel = WB_SEL_PC4;
                    CL_LOAD:         wb_sel = WB_SEL_MEM;
                    default:         wb_sel = WB_SEL_ALU;
                endcase
                case (cls_reg)
                    CL_JAL:  pc_sel = PC_SEL_IMM;
                    CL_JALR: pc_sel = PC_SEL_JALR;
                    default: pc_sel = PC_SEL_PLUS4;
                endcase
            end
            default: ;
        endcase
        if (rst) begin
            imem_req = 1'b0;
            ir_we    = 1'b0;
            pc_we    = 1'b0;
            dmem_req = 1'b0;
            rf_we    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_FETCH;
            cls_reg     <= CL_OP;
            funct3_reg  <= 3'd0;
            rd_reg      <= 5'd0;
            illegal_reg <= 1'b0;
            instret_reg <= '0;
        end else begin
            if (pc_we)
                instret_reg <= instret_reg + CNT_W'(1);
            case (state_reg)
                ST_FETCH: begin
                    if (imem_ready)
                        state_reg <= ST_DECODE;
                end
                ST_DECODE: begin
                    cls_reg    <= dec_cls;
                    funct3_reg <= funct3;
                    rd_reg     <= rd;
                    if (dec_illegal) begin
                        state_reg   <= ST_TRAP;
                        illegal_reg <= 1'b1;
                    end else begin
                        state_reg <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (cls_reg == CL_BRANCH)
                        state_reg <= ST_FETCH;
                    else if (cls_reg == CL_LOAD || cls_reg == CL_STORE)
                        state_reg <= ST_MEM;
                    else
                        state_reg <= ST_WB;
                end
                ST_MEM: begin
                    if (dmem_ready)
                        state_reg <= (cls_reg == CL_STORE) ? ST_FETCH : ST_WB;
                end
                ST_WB:   state_reg <= ST_FETCH;
                ST_TRAP: state_reg <= ST_TRAP;
                default: state_reg <= ST_FETCH;
            endcase
        end
    end

    assign dmem_size = funct3_reg;
    assign illegal   = illegal_reg;
    assign instret   = instret_reg;

endmodule

// File: tb/tb_mc_control.sv
// Cycle-level scoreboard bench for mc_control: per-cycle stimulus and the
// expected control vector are queued together, then replayed and compared.
module tb_mc_control;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [6:0]    opcode;
    logic [2:0]    funct3;
    logic [4:0]    rd;
    logic          branch_taken;
    logic          imem_ready;
    logic          dmem_ready;
    logic          imem_req, ir_we, pc_we, alu_a_sel, alu_b_sel;
    logic          dmem_req, dmem_we, rf_we, illegal;
    logic [1:0]    pc_sel, wb_sel;
    logic [2:0]    dmem_size;
    logic [CW-1:0] instret;

    mc_control #(.CNT_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .opcode       (opcode),
        .funct3       (funct3),
        .rd           (rd),
        .branch_taken (branch_taken),
        .imem_ready   (imem_ready),
        .dmem_ready   (dmem_ready),
        .imem_req     (imem_req),
        .ir_we        (ir_we),
        .pc_we        (pc_we),
        .pc_sel       (pc_sel),
        .alu_a_sel    (alu_a_sel),
        .alu_b_sel    (alu_b_sel),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_size    (dmem_size),
        .rf_we        (rf_we),
        .wb_sel       (wb_sel),
        .illegal      (illegal),
        .instret      (instret)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        ir;
        logic        dr;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic        bt;
        logic [15:0] ctl;
        logic [15:0] mask;
        logic [3:0]  cnt;
        logic        chk_cnt;
    } cyc_t;

    cyc_t sb[$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc_idx  = 0;

    int         m_cnt;
    logic [2:0] m_f3;
    logic [6:0] g_op;
    logic [2:0] g_f3;
    logic [4:0] g_rd;
    logic       g_bt;

    localparam logic [15:0] RST_MASK = 16'hE108;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc_idx, obs, exp);
        end
    endtask

    function automatic logic [15:0] mk(logic ireq, logic irwe, logic pcwe, logic [1:0] pcs,
                                       logic a, logic b, logic dreq, logic dwe, logic [2:0] sz,
                                       logic rfwe, logic [1:0] wbs, logic ill);
        return {ireq, irwe, pcwe, pcs, a, b, dreq, dwe, sz, rfwe, wbs, ill};
    endfunction

    task automatic push(input logic r, input logic ir, input logic dr,
                        input logic [15:0] ctl, input logic [15:0] mask, input logic chk);
        cyc_t c;
        c.rst = r; c.ir = ir; c.dr = dr;
        c.op = g_op; c.f3 = g_f3; c.rd = g_rd; c.bt = g_bt;
        c.ctl = ctl; c.mask = mask;
        c.cnt = m_cnt[3:0]; c.chk_cnt = chk;
        sb.push_back(c);
        if (!r && ctl[13])
            m_cnt = (m_cnt + 1) % 16;
    endtask

    task automatic push_rst(input int n);
        for (int i = 0; i < n; i++)
            push(1'b1, 1'b1, 1'b1, 16'h0000, RST_MASK, 1'b0);
        m_cnt = 0;
        m_f3  = 3'd0;
    endtask

    task automatic gen(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rdi,
                       input logic bt, input int iw, input int dw, input logic abort_mem);
        logic lui, auipc, jal, jalr, br, ld, st, opi, opr, fen, bad;
        logic [1:0] pcs, wbs;
        g_op = op; g_f3 = f3; g_rd = rdi; g_bt = bt;
        lui = (op == 7'b0110111); auipc = (op == 7'b0010111);
        jal = (op == 7'b1101111); jalr  = (op == 7'b1100111);
        br  = (op == 7'b1100011); ld    = (op == 7'b0000011);
        st  = (op == 7'b0100011); opi   = (op == 7'b0010011);
        opr = (op == 7'b0110011); fen   = (op == 7'b0001111);
        bad = !(lui | auipc | jal | jalr | br | ld | st | opi | opr | fen);
        for (int i = 0; i < iw; i++)
            push(1'b0, 1'b0, 1'b1, mk(1,0,0,2'd0,0,0,0,0,m_f3,0,2'd0,0), 16'hFFFF, 1'b1);
        push(1'b0, 1'b1, 1'b0, mk(1,1,0,2'd0,0,0,0,0,m_f3,0,2'd0,0), 16'hFFFF, 1'b1);
        push(1'b0, 1'b1, 1'b1, mk(0,0,0,2'd0,0,0,0,0,m_f3,0,2'd0,0), 16'hFFFF, 1'b1);
        m_f3 = f3;
        if (bad) begin
            for (int i = 0; i < 4; i++)
                push(1'b0, 1'b1, 1'b1, mk(0,0,0,2'd0,0,0,0,0,f3,0,2'd0,1), 16'hFFFF, 1'b1);
            return;
        end
        push(1'b0, 1'b1, 1'b1,
             mk(0,0,br,{1'b0, br & bt},auipc,auipc|opi|ld|st|jalr,0,0,f3,0,2'd0,0),
             16'hFFFF, 1'b1);
        if (br) return;
        if (ld | st) begin
            for (int i = 0; i < dw; i++)
                push(1'b0, 1'b1, 1'b0, mk(0,0,0,2'd0,0,0,1,st,f3,0,2'd0,0), 16'hFFFF, 1'b1);
            if (abort_mem) begin
                push_rst(1);
                return;
            end
            push(1'b0, 1'b0, 1'b1, mk(0,0,st,2'd0,0,0,1,st,f3,0,2'd0,0), 16'hFFFF, 1'b1);
            if (st) return;
        end
        pcs = jal ? 2'd1 : (jalr ? 2'd2 : 2'd0);
        wbs = lui ? 2'd3 : ((jal | jalr) ? 2'd2 : (ld ? 2'd1 : 2'd0));
        push(1'b0, 1'b1, 1'b1, mk(0,0,1,pcs,0,0,0,0,f3,(rdi != 5'd0) && !fen,wbs,0),
             16'hFFFF, 1'b1);
    endtask

    initial begin
        cyc_t c;
        rst = 1'b1; opcode = '0; funct3 = '0; rd = '0;
        branch_taken = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
        m_cnt = 0; m_f3 = 3'd0;
        g_op = '0; g_f3 = '0; g_rd = '0; g_bt = 1'b0;

        push_rst(2);
        gen(7'b0110011, 3'b000, 5'd3, 0, 0, 0, 0);  // ADD x3,x1,x2
        gen(7'b0000011, 3'b010, 5'd5, 0, 0, 2, 0);  // LW x5,4(x1)
        gen(7'b1100011, 3'b000, 5'd0, 1, 0, 0, 0);  // BEQ taken
        gen(7'b1100011, 3'b000, 5'd0, 0, 0, 0, 0);  // BEQ not taken
        gen(7'b1100111, 3'b000, 5'd0, 0, 0, 0, 0);  // JALR x0
        gen(7'b1101111, 3'b000, 5'd1, 0, 2, 0, 0);  // JAL x1, fetch waits
        gen(7'b0110111, 3'b011, 5'd7, 0, 0, 0, 0);  // LUI
        gen(7'b0010111, 3'b001, 5'd8, 0, 1, 0, 0);  // AUIPC
        gen(7'b0001111, 3'b000, 5'd9, 0, 0, 0, 0);  // FENCE
        gen(7'b0100011, 3'b010, 5'd0, 0, 0, 1, 0);  // SW with a wait
        gen(7'b0100011, 3'b000, 5'd0, 0, 0, 0, 0);  // SB zero-wait
        gen(7'b0000011, 3'b100, 5'd0, 0, 0, 0, 0);  // LBU x0
        for (int i = 0; i < 10; i++)
            gen(7'b0010011, 3'b000, 5'(i + 1), 0, 0, 0, 0);  // ADDI, drives instret wrap
        gen(7'b0100011, 3'b010, 5'd0, 0, 0, 2, 1);  // SW reset mid-MEM
        gen(7'b0110011, 3'b000, 5'd4, 0, 0, 0, 0);
        gen(7'b1111111, 3'b101, 5'd2, 0, 0, 0, 0);  // illegal 0x7F
        push_rst(1);
        gen(7'b1110011, 3'b000, 5'd1, 0, 0, 0, 0);  // SYSTEM is illegal
        push_rst(1);
        gen(7'b0110011, 3'b000, 5'd6, 0, 0, 0, 0);

        while (sb.size() > 0) begin
            c = sb.pop_front();
            @(posedge clk);
            #1;
            rst = c.rst; imem_ready = c.ir; dmem_ready = c.dr;
            opcode = c.op; funct3 = c.f3; rd = c.rd; branch_taken = c.bt;
            @(negedge clk);
            check("ctl", 32'({imem_req, ir_we, pc_we, pc_sel, alu_a_sel, alu_b_sel, dmem_req,
                              dmem_we, dmem_size, rf_we, wb_sel, illegal} & c.mask),
                  32'(c.ctl & c.mask));
            if (c.chk_cnt)
                check("instret", 32'(instret), 32'(c.cnt));
            cyc_idx++;
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
